// File: rtl/md_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package md_pkg;

    localparam int MD_DATA_W = 32;
    localparam int ITER_W    = $clog2(MD_DATA_W) + 1;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MULT  = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Sign conditioning: absolute value of an operand, or conditional two's-complement negation of a result.
// Latency: combinational.
// Backpressure: none.
// Ports: val_i value in; abs_i=1 returns |val_i|; abs_i=0 negates when neg_i=1; res_o result.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         abs_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    logic do_neg;

    assign do_neg = abs_i ? val_i[W-1] : neg_i;
    assign res_o  = do_neg ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit writing the HI/LO registers.
// Latency: md_done the cycle after edge E0+33; divide-by-zero finishes after edge E0+1.
// Backpressure: md_start is accepted only in IDLE; starts while busy are dropped.
// Ports: clk/reset; md_start, md_op, md_a, md_b request; md_busy, md_done, md_div_zero status;
//        hi_out/lo_out are the HI/LO registers, written only when an operation completes.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              md_start,
    input  logic              md_op,
    input  logic [DATA_W-1:0] md_a,
    input  logic [DATA_W-1:0] md_b,
    output logic              md_busy,
    output logic              md_done,
    output logic              md_div_zero,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    md_state_e state_q, state_d;

    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              op_q, op_d;
    // Accumulator carries one guard bit so that subtracting the most negative
    // multiplicand cannot overflow the Booth partial product.
    logic [DATA_W:0]   acc_q, acc_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              qm1_q, qm1_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic              quot_neg_q, quot_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              div_zero_q, div_zero_d;

    logic [DATA_W-1:0] abs_a, abs_b, quot_fix, rem_fix;
    logic [DATA_W:0]   mcand_ext, booth_sum;
    logic [DATA_W:0]   r_shift, trial;
    logic              last_iter, divisor_zero;

    md_sign_fix #(.W(DATA_W)) u_abs_a (.val_i(md_a), .abs_i(1'b1), .neg_i(1'b0), .res_o(abs_a));
    md_sign_fix #(.W(DATA_W)) u_abs_b (.val_i(md_b), .abs_i(1'b1), .neg_i(1'b0), .res_o(abs_b));
    md_sign_fix #(.W(DATA_W)) u_quot  (.val_i(q_q), .abs_i(1'b0), .neg_i(quot_neg_q), .res_o(quot_fix));
    md_sign_fix #(.W(DATA_W)) u_rem   (.val_i(acc_q[DATA_W-1:0]), .abs_i(1'b0), .neg_i(rem_neg_q),
                                       .res_o(rem_fix));

    assign last_iter    = (cnt_q == ITER_W'(DATA_W - 1));
    assign divisor_zero = (mcand_q == '0);

    // Booth step: recode {Q[0], q-1}, then the caller shifts {acc, Q, q-1} right arithmetically.
    assign mcand_ext = {mcand_q[DATA_W-1], mcand_q};
    always_comb begin
        booth_sum = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_ext;
            2'b10:   booth_sum = acc_q - mcand_ext;
            default: booth_sum = acc_q;
        endcase
    end

    // Restoring divide step on magnitudes: shift the next dividend bit into the
    // partial remainder and keep the subtraction only if it stays non-negative.
    assign r_shift = {acc_q[DATA_W-1:0], q_q[DATA_W-1]};
    assign trial   = r_shift - {1'b0, mcand_q};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (md_start) state_d = (md_op == MD_DIV) ? ST_DIV : ST_MULT;
            ST_MULT:  if (last_iter) state_d = ST_FIXUP;
            ST_DIV: begin
                if (divisor_zero)   state_d = ST_DONE;
                else if (last_iter) state_d = ST_FIXUP;
            end
            ST_FIXUP: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        md_busy = (state_q != ST_IDLE);
        md_done = (state_q == ST_DONE);
    end

    assign md_div_zero = div_zero_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

    // Datapath next-state
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        mcand_d    = mcand_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    op_d       = md_op;
                    cnt_d      = '0;
                    acc_d      = '0;
                    qm1_d      = 1'b0;
                    div_zero_d = 1'b0;
                    quot_neg_d = md_a[DATA_W-1] ^ md_b[DATA_W-1];
                    rem_neg_d  = md_a[DATA_W-1];
                    if (md_op == MD_DIV) begin
                        q_d     = abs_a;
                        mcand_d = abs_b;
                    end else begin
                        q_d     = md_b;
                        mcand_d = md_a;
                    end
                end
            end
            ST_MULT: begin
                acc_d = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
                q_d   = {booth_sum[0], q_q[DATA_W-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + ITER_W'(1);
            end
            ST_DIV: begin
                if (divisor_zero) begin
                    div_zero_d = 1'b1;
                end else begin
                    acc_d = trial[DATA_W] ? r_shift : trial;
                    q_d   = {q_q[DATA_W-2:0], ~trial[DATA_W]};
                    cnt_d = cnt_q + ITER_W'(1);
                end
            end
            ST_FIXUP: begin
                if (op_q == MD_DIV) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = acc_q[DATA_W-1:0];
                    lo_d = q_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            op_q       <= 1'b0;
            acc_q      <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            mcand_q    <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            qm1_q      <= qm1_d;
            mcand_q    <= mcand_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written corner sequences,
// and randomized operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_start;
    logic        md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_busy;
    logic        md_done;
    logic        md_div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] cur_hi, cur_lo;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .md_start   (md_start),
        .md_op      (md_op),
        .md_a       (md_a),
        .md_b       (md_b),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_div_zero(md_div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: signed 64-bit product, or C-style truncating divide; divide by zero leaves HI/LO.
    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi_in, input logic [31:0] lo_in,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = hi_in;
        lo = lo_in;
        dz = 1'b0;
        if (op == 1'b0) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    // Issue one operation and check timing and results; repulse>0 re-pulses md_start
    // with different operands so it is sampled at edge E0+repulse.
    task automatic run_op(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz,
                          input int exp_lat, input int repulse);
        int lat;
        bit busy_ok;
        @(negedge clk);
        md_op    = op;
        md_a     = a;
        md_b     = b;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        chk({name, "_start_busy"}, 32'(md_busy), 32'd1);
        chk({name, "_start_dz_clr"}, 32'(md_div_zero), 32'd0);
        lat     = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            if (n == repulse) begin
                @(negedge clk);
                md_start = 1'b1;
                md_op    = ~op;
                md_a     = ~a;
                md_b     = b + 32'd1;
            end
            @(posedge clk);
            #1;
            md_start = 1'b0;
            if (md_done) lat = n;
            else if (!md_busy) busy_ok = 1'b0;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy_held"}, 32'(busy_ok), 32'd1);
        chk({name, "_hi"}, hi_out, exp_hi);
        chk({name, "_lo"}, lo_out, exp_lo);
        chk({name, "_dz"}, 32'(md_div_zero), 32'(exp_dz));
        chk({name, "_done_busy"}, 32'(md_busy), 32'd1);
        @(posedge clk);
        #1;
        chk({name, "_busy_drop"}, 32'(md_busy), 32'd0);
        chk({name, "_done_pulse"}, 32'(md_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_hold_hi"}, hi_out, exp_hi);
        chk({name, "_hold_lo"}, lo_out, exp_lo);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ehi, elo, ra, rb;
        logic        edz, rop;

        vecs[0] = '{"mul_7_m3",     1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
        vecs[1] = '{"mul_min_min",  1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[2] = '{"mul_m1_m1",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33};
        vecs[3] = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[4] = '{"div_7_m2",     1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[5] = '{"div_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
        vecs[6] = '{"div_629_18",   1'b1, 32'h0000_0275, 32'h0000_0012, 32'h0000_0011, 32'h0000_0022, 1'b0, 33};
        vecs[7] = '{"div_5_0",      1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b1, 1};
        vecs[8] = '{"mul_3_4",      1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0, 33};

        reset    = 1'b1;
        md_start = 1'b0;
        md_op    = 1'b0;
        md_a     = '0;
        md_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_done", 32'(md_done), 32'd0);
        chk("rst_dz", 32'(md_div_zero), 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                   vecs[i].exp_dz, vecs[i].exp_lat, 0);
        end
        cur_hi = 32'h0;
        cur_lo = 32'hC;

        // Start request while busy must be ignored.
        model(1'b0, 32'h1234_5678, 32'hFEDC_BA98, cur_hi, cur_lo, ehi, elo, edz);
        run_op("mul_repulse", 1'b0, 32'h1234_5678, 32'hFEDC_BA98, ehi, elo, edz, 33, 5);
        cur_hi = ehi;
        cur_lo = elo;

        // Reset between clock edges in the middle of a multiply.
        @(negedge clk);
        md_op    = 1'b0;
        md_a     = 32'h0BAD_F00D;
        md_b     = 32'h7654_3210;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(md_busy), 32'd0);
        chk("midrst_done", 32'(md_done), 32'd0);
        chk("midrst_dz", 32'(md_div_zero), 32'd0);
        chk("midrst_hi", hi_out, 32'd0);
        chk("midrst_lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_busy", 32'(md_busy), 32'd0);
        chk("postrst_hi", hi_out, 32'd0);
        chk("postrst_lo", lo_out, 32'd0);
        run_op("postrst_mul_3_4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 0);
        cur_hi = 32'd0;
        cur_lo = 32'd12;

        for (int i = 0; i < 30; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 100));
                3:       rb = -32'($urandom_range(1, 100));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, cur_hi, cur_lo, ehi, elo, edz);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, ehi, elo, edz, edz ? 1 : 33, 0);
            cur_hi = ehi;
            cur_lo = elo;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
